// File: rtl/ioblock_n.sv
// Configurable N-channel pad I/O block with serial configuration chain.
// Define IOBLOCK_N_INSYNC_EN for a two-stage input synchroniser on the registered input path.
module ioblock_n #(
  parameter int WIDTH = 4
) (
  input  logic             IOCLK,
  input  logic             RST,
  inout  wire  [WIDTH-1:0] PIN,
  input  logic [WIDTH-1:0] TS,
  input  logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] IN,
  input  logic             CFG_EN,
  input  logic             CFG_DIN,
  input  logic             CFG_LOAD,
  output logic             CFG_DOUT
);

  localparam int CHAIN_W = 4 * WIDTH;

  logic [CHAIN_W-1:0] r_chain;
  logic [CHAIN_W-1:0] r_active;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_ts;
  logic [WIDTH-1:0]   r_in1;
  logic [WIDTH-1:0]   w_in_reg;

  // Load samples the chain before this edge's shift, so both may share an edge.
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      r_chain  <= '0;
      r_active <= '0;
    end else begin
      if (CFG_LOAD) r_active <= r_chain;
      if (CFG_EN)   r_chain  <= {r_chain[CHAIN_W-2:0], CFG_DIN};
    end
  end

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      r_out <= '0;
      r_ts  <= '0;
      r_in1 <= '0;
    end else begin
      r_out <= OUT;
      r_ts  <= TS;
      r_in1 <= PIN;
    end
  end

`ifdef IOBLOCK_N_INSYNC_EN
  logic [WIDTH-1:0] r_in2;

  always_ff @(posedge IOCLK) begin
    if (RST) r_in2 <= '0;
    else     r_in2 <= r_in1;
  end

  assign w_in_reg = r_in2;
`else
  assign w_in_reg = r_in1;
`endif

  assign CFG_DOUT = r_chain[CHAIN_W-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic       w_dorreg;
      logic       w_oreg;
      logic [1:0] w_tsmux;
      logic       w_out_eff;
      logic       w_ts_eff;
      logic       w_drive;

      assign w_dorreg  = r_active[4*gi];
      assign w_oreg    = r_active[4*gi+1];
      assign w_tsmux   = r_active[4*gi+3 -: 2];
      assign w_out_eff = w_oreg ? r_out[gi] : OUT[gi];
      assign w_ts_eff  = w_oreg ? r_ts[gi]  : TS[gi];

      always_comb begin
        w_drive = 1'b0;
        case (w_tsmux)
          2'b00:   w_drive = 1'b0;
          2'b01:   w_drive = w_ts_eff;
          2'b10:   w_drive = 1'b1;
          default: w_drive = ~w_ts_eff;
        endcase
      end

      assign PIN[gi] = w_drive ? w_out_eff : 1'bz;
      assign IN[gi]  = w_dorreg ? w_in_reg[gi] : PIN[gi];
    end
  endgenerate

endmodule

// File: tb/tb_ioblock_n.sv
// Randomised scoreboard bench for ioblock_n: a stimulus process queues per-cycle
// expected pad/fabric values from a behavioural model; a negedge monitor compares.
`timescale 1ns/1ps
module tb_ioblock_n;

  localparam int W = 4;
  localparam int N = 4 * W;
`ifdef IOBLOCK_N_INSYNC_EN
  localparam int IN_DEPTH = 2;
`else
  localparam int IN_DEPTH = 1;
`endif

  typedef struct {
    logic [W-1:0] pin;
    logic [W-1:0] inv;
    logic         dout;
  } exp_t;

  logic         IOCLK = 1'b0;
  logic         RST = 1'b1;
  logic         CFG_EN = 1'b0;
  logic         CFG_DIN = 1'b0;
  logic         CFG_LOAD = 1'b0;
  logic [W-1:0] TS = '0;
  logic [W-1:0] OUT = '0;
  logic [W-1:0] ext_en = '1;
  logic [W-1:0] ext_val = '0;
  wire  [W-1:0] pin;
  wire  [W-1:0] in_w;
  wire          cfg_dout;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_ext
      assign pin[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
    end
  endgenerate

  ioblock_n #(.WIDTH(W)) dut (
    .IOCLK   (IOCLK),
    .RST     (RST),
    .PIN     (pin),
    .TS      (TS),
    .OUT     (OUT),
    .IN      (in_w),
    .CFG_EN  (CFG_EN),
    .CFG_DIN (CFG_DIN),
    .CFG_LOAD(CFG_LOAD),
    .CFG_DOUT(cfg_dout)
  );

  always #5 IOCLK = ~IOCLK;

  // Behavioural model: chain and active config as bit vectors, last-cycle
  // fabric values, and a history of resolved pad values for the input delay.
  logic [N-1:0] m_chain;
  logic [N-1:0] m_act;
  logic [W-1:0] m_prev_out;
  logic [W-1:0] m_prev_ts;
  logic [W-1:0] m_pin_hist[$];

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic model_reset();
    m_chain    = '0;
    m_act      = '0;
    m_prev_out = '0;
    m_prev_ts  = '0;
    m_pin_hist = {};
    for (int i = 0; i < IN_DEPTH; i++) m_pin_hist.push_back('0);
  endtask

  task automatic step(input logic rst, input logic en, input logic din, input logic load,
                      input logic [W-1:0] ts, input logic [W-1:0] out);
    exp_t         e;
    logic [W-1:0] drv;
    logic [W-1:0] dval;
    logic [W-1:0] delayed;
    logic [1:0]   mux;
    logic         eo;
    logic         et;
    RST      = rst;
    CFG_EN   = en;
    CFG_DIN  = din;
    CFG_LOAD = load;
    TS       = ts;
    OUT      = out;
    delayed  = m_pin_hist[IN_DEPTH-1];
    for (int k = 0; k < W; k++) begin
      mux     = m_act[4*k+2 +: 2];
      eo      = m_act[4*k+1] ? m_prev_out[k] : out[k];
      et      = m_act[4*k+1] ? m_prev_ts[k]  : ts[k];
      drv[k]  = (mux == 2'b10) || (mux == 2'b01 && et) || (mux == 2'b11 && !et);
      dval[k] = eo;
    end
    // The bench drives every pad the block leaves floating, so pad values stay known.
    ext_val = rnd();
    ext_en  = ~drv;
    e.pin   = (drv & dval) | (~drv & ext_val);
    for (int k = 0; k < W; k++) e.inv[k] = m_act[4*k] ? delayed[k] : e.pin[k];
    e.dout  = m_chain[N-1];
    sb.push_back(e);
    @(posedge IOCLK);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (load) m_act = m_chain;
      if (en)   m_chain = {m_chain[N-2:0], din};
      m_prev_out = out;
      m_prev_ts  = ts;
      m_pin_hist.push_front(e.pin);
      void'(m_pin_hist.pop_back());
    end
  endtask

  task automatic shift_load(input logic [N-1:0] val);
    for (int b = N - 1; b >= 0; b--) step(1'b0, 1'b1, val[b], 1'b0, rnd(), rnd());
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd(), rnd());
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, req);
    end
  endtask

  always @(negedge IOCLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      cyc++;
      chk("pin", pin, mon_e.pin);
      chk("in", in_w, mon_e.inv);
      chk("cfg_dout", {{(W-1){1'b0}}, cfg_dout}, {{(W-1){1'b0}}, mon_e.dout});
      $display("cyc=%0d rst=%b ts=%b out=%b pin=%b in=%b dout=%b", cyc, RST, TS, OUT, pin, in_w, cfg_dout);
    end
  end

  logic [3:0] pat;

  initial begin
    @(posedge IOCLK);
    #1;
    model_reset();

    // Fresh reset: block never drives, IN follows the pad.
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, rnd(), rnd());

    // ch0 TSMUX=01 comb, ch1 TSMUX=10 OREG, ch2 TSMUX=11 DORREG, ch3 off.
    shift_load(16'h0DA4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0010);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100);

    // Pattern 1,0,1,1 with load on the third shift edge, then flush to CFG_DOUT.
    step(1'b1, 1'b0, 1'b0, 1'b0, rnd(), rnd());
    pat = 4'b1011;
    for (int b = 3; b >= 0; b--)
      step(1'b0, 1'b1, pat[b], (b == 1) ? 1'b1 : 1'b0, rnd(), rnd());
    repeat (14) step(1'b0, 1'b1, 1'b0, 1'b0, rnd(), rnd());

    // Reset after seven shifted bits discards the partial chain.
    repeat (7) step(1'b0, 1'b1, 1'b1, 1'b0, rnd(), rnd());
    step(1'b1, 1'b1, 1'b1, 1'b1, rnd(), rnd());
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, rnd(), rnd());

    for (int it = 0; it < 40; it++) begin
      for (int b = 0; b < N; b++)
        step($urandom_range(0, 63) == 0, 1'b1, rbit(), $urandom_range(0, 7) == 0, rnd(), rnd());
      step(1'b0, 1'b0, 1'b0, 1'b1, rnd(), rnd());
      repeat (20) step(1'b0, rbit(), rbit(), 1'b0, rnd(), rnd());
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge IOCLK);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
